mips32_mem_arbiter: RTL and testbench

//   Arbitrates a single-port 32-bit word memory between three requesters of the pipelined MIPS32 core:

---
 rtl/mips32_mem_arbiter_if.sv | 55 +++++
 rtl/mips32_mem_arbiter.sv | 105 ++++++++++
 tb/tb_mips32_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_arbiter_if.sv
// Request/grant/return bundle between the three MIPS32 requesters, the arbiter and the
// single-port word memory.
interface mips32_mem_arbiter_if #(
  parameter int unsigned AW = 10
) ();
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [31:0]   host_rdata;

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority (host > data > fetch) arbiter for a single-port word memory, with a
// starvation boost for fetch and tagged routing of the 1-cycle read return.
module mips32_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk1,
  input logic                rst_n,
  input logic                halted,
  mips32_mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {PortHost, PortData, PortFetch} port_e;

  logic [CntW-1:0] starve_q, starve_d;
  logic            tag_valid_q, tag_valid_d;
  port_e           tag_port_q, tag_port_d;

  logic            boost;
  logic            host_gnt, dmem_gnt, imem_gnt;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;

  assign boost = (starve_q == CntW'(STARVE_LIMIT));

  // Grants are gated during reset so nothing is issued while the return tag is cleared.
  always_comb begin
    host_gnt = 1'b0;
    dmem_gnt = 1'b0;
    imem_gnt = 1'b0;
    if (rst_n) begin
      if (bus.host_req) begin
        host_gnt = 1'b1;
      end else if (!halted) begin
        if (bus.imem_req && (boost || !bus.dmem_req)) begin
          imem_gnt = 1'b1;
        end else if (bus.dmem_req) begin
          dmem_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end else if (dmem_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.dmem_we;
      mem_addr  = bus.dmem_addr;
      mem_wdata = bus.dmem_wdata;
    end else if (imem_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = bus.imem_addr;
    end
  end

  always_comb begin
    tag_valid_d = mem_en && !mem_we;
    tag_port_d  = host_gnt ? PortHost : (dmem_gnt ? PortData : PortFetch);
    starve_d    = '0;
    if (bus.imem_req && !imem_gnt) begin
      starve_d = boost ? starve_q : starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      starve_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_port_q  <= PortHost;
    end else begin
      starve_q    <= starve_d;
      tag_valid_q <= tag_valid_d;
      tag_port_q  <= tag_port_d;
    end
  end

  assign bus.host_gnt  = host_gnt;
  assign bus.dmem_gnt  = dmem_gnt;
  assign bus.imem_gnt  = imem_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Returns are also masked while reset is asserted so a read in flight is dropped.
  assign bus.host_rvalid = rst_n && tag_valid_q && (tag_port_q == PortHost);
  assign bus.dmem_rvalid = rst_n && tag_valid_q && (tag_port_q == PortData);
  assign bus.imem_rvalid = rst_n && tag_valid_q && (tag_port_q == PortFetch);
  assign bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.dmem_rdata  = bus.dmem_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.imem_rdata  = bus.imem_rvalid ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomized and directed bench for mips32_mem_arbiter: a priority/starvation model predicts
// grants each cycle and queues expected read returns for an independent monitor.
module tb_mips32_mem_arbiter;
  localparam int unsigned AW    = 6;
  localparam int unsigned Limit = 4;
  localparam int unsigned Depth = 2 ** AW;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halted;

  mips32_mem_arbiter_if #(.AW(AW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .STARVE_LIMIT(Limit)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .halted(halted),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    int          port;
    logic [31:0] data;
  } ret_t;

  int          vectors    = 0;
  int          miscompares = 0;
  int          starve_ref = 0;
  logic [2:0]  last_gnt   = 3'b0;
  logic [31:0] mem_arr [Depth];
  logic [31:0] shadow  [Depth];
  ret_t        exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural memory: one access per cycle, read data one cycle later.
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  // Reference model: who should win this cycle, and what the memory should see.
  always @(negedge clk1) begin : sb
    logic [2:0]    eg;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [31:0]   ewd;
    ret_t          e;
    eg = 3'b0;
    if (rst_n) begin
      if (bus.host_req) eg = 3'b001;
      else if (!halted) begin
        if (bus.imem_req && (!bus.dmem_req || starve_ref >= int'(Limit))) eg = 3'b100;
        else if (bus.dmem_req) eg = 3'b010;
      end
    end
    ewe = 1'b0;
    ea  = '0;
    ewd = 32'h0;
    if (eg[0]) begin
      ewe = bus.host_we; ea = bus.host_addr; ewd = bus.host_wdata;
    end else if (eg[1]) begin
      ewe = bus.dmem_we; ea = bus.dmem_addr; ewd = bus.dmem_wdata;
    end else if (eg[2]) begin
      ea = bus.imem_addr;
    end
    chk("gnt", 32'({bus.imem_gnt, bus.dmem_gnt, bus.host_gnt}), 32'(eg));
    chk("mem_en", 32'(bus.mem_en), 32'(|eg));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    if (ewe || eg == 3'b0) chk("mem_wdata", bus.mem_wdata, ewd);
    if (ewe) begin
      shadow[ea] = ewd;
    end else if (eg != 3'b0) begin
      e.port = eg[0] ? 0 : (eg[1] ? 1 : 2);
      e.data = shadow[ea];
      exp_q.push_back(e);
    end
    if (!rst_n) starve_ref = 0;
    else if (bus.imem_req && !eg[2]) starve_ref++;
    else starve_ref = 0;
    last_gnt = eg;
  end

  // Monitor: compares every return path against the head of the expected-return queue.
  always @(posedge clk1) begin : mon
    logic [2:0]  erv;
    logic [31:0] edat;
    ret_t        e;
    #2;
    erv  = 3'b0;
    edat = 32'h0;
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      erv[e.port] = 1'b1;
      edat = e.data;
    end
    chk("rvalid", 32'({bus.imem_rvalid, bus.dmem_rvalid, bus.host_rvalid}), 32'(erv));
    chk("host_rdata", bus.host_rdata, erv[0] ? edat : 32'h0);
    chk("dmem_rdata", bus.dmem_rdata, erv[1] ? edat : 32'h0);
    chk("imem_rdata", bus.imem_rdata, erv[2] ? edat : 32'h0);
  end

  task automatic step();
    @(posedge clk1);
    #1;
    if (last_gnt[0]) bus.host_req = 1'b0;
    if (last_gnt[1]) bus.dmem_req = 1'b0;
    if (last_gnt[2]) bus.imem_req = 1'b0;
  endtask

  task automatic host(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
  endtask

  task automatic dmem(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    bus.dmem_req = 1'b1; bus.dmem_we = we; bus.dmem_addr = a; bus.dmem_wdata = d;
  endtask

  task automatic imem(input logic [AW-1:0] a);
    bus.imem_req = 1'b1; bus.imem_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    halted = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 32'h0;
    bus.dmem_req = 1'b0; bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = 32'h0;
    bus.imem_req = 1'b0; bus.imem_addr = '0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < int'(Depth); i++) begin
      mem_arr[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    repeat (3) step();
    rst_n = 1'b1;

    // Host write then readback.
    host(1'b1, '0, 32'h2801000a); step();
    host(1'b0, '0, 32'h0);        step();
    step();

    // All three at once: host, then data, then fetch.
    host(1'b0, AW'(1), 32'h0); dmem(1'b0, AW'(2), 32'h0); imem(AW'(3));
    repeat (4) step();

    // Data held continuously starves fetch until the boost kicks in.
    imem(AW'(5));
    for (int i = 0; i < 6; i++) begin
      dmem(1'b0, AW'(i), 32'h0);
      step();
    end
    bus.dmem_req = 1'b0;
    step();

    // Halted: only the host gets through.
    halted = 1'b1;
    dmem(1'b0, AW'(1), 32'h0);
    imem(AW'(2));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) host(1'b0, '0, 32'h0);
      step();
    end
    halted = 1'b0;
    repeat (3) step();

    // Back-to-back fetches of freshly written words.
    for (int a = 0; a < 4; a++) begin
      host(1'b1, AW'(a), $urandom); step();
    end
    for (int a = 0; a < 4; a++) begin
      imem(AW'(a)); step();
    end
    step();

    // Reset right after a granted load drops the return.
    dmem(1'b0, '0, 32'h0); step();
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();

    for (int c = 0; c < 3000; c++) begin
      if (!bus.host_req && $urandom_range(0, 7) == 0)
        host(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      if (!bus.dmem_req && $urandom_range(0, 2) == 0)
        dmem(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      if (!bus.imem_req && $urandom_range(0, 1) == 0)
        imem(AW'($urandom_range(0, 15)));
      if (bus.dmem_req && $urandom_range(0, 15) == 0) bus.dmem_req = 1'b0;
      if ($urandom_range(0, 49) == 0) halted = ~halted;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    bus.host_req = 1'b0; bus.dmem_req = 1'b0; bus.imem_req = 1'b0;
    halted = 1'b0;
    rst_n  = 1'b1;
    repeat (3) step();
    chk("returns_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
